// File: rtl/hpu_pkg.sv
`default_nettype none
// ============================================================================
// hpu_pkg : shared video-memory map, pixel/colour types and load-FSM encoding
// Rev 1.0
// ============================================================================
package hpu_pkg;

  localparam logic [15:0] PALETTE_OFFSET   = 16'h2AC0;
  localparam logic [15:0] NAMETABLE_OFFSET = 16'h2000;
  localparam logic [15:0] ATTR_OFFSET      = 16'h23C0;
  localparam logic [15:0] TILE_OFFSET      = 16'h0000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [1:0] pal;
    logic [2:0] idx;
  } tile_pixel_t;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_REQ   = 2'd1,
    LD_STORE = 2'd2
  } load_state_t;

  // Even byte carries {G,B}; only the low nibble of the odd byte is red.
  function automatic rgb444_t make_entry(input logic [7:0] lo, input logic [3:0] red);
    make_entry = '{r: red, g: lo[7:4], b: lo[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpu_palette_ram.sv
`default_nettype none
// ============================================================================
// hpu_palette_ram : NUM_ENTRIES x 12 register file, one sync write port,
//                   one registered read port returning pre-write data
// Rev 1.0
// ============================================================================
module hpu_palette_ram #(
  parameter int NUM_ENTRIES = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] waddr,
  input  logic [11:0]                    wdata,
  input  logic [$clog2(NUM_ENTRIES)-1:0] raddr,
  output logic [11:0]                    rdata
);

  logic [11:0] r_mem [NUM_ENTRIES];
  logic [11:0] r_rdata;

  // Read and write share one edge, so a same-entry collision returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (we) begin
        r_mem[waddr] <= wdata;
      end
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hpu_palette_out.sv
`default_nettype none
// ============================================================================
// hpu_palette_out : per-frame palette refill from video memory and a fixed
//                   2-cycle pixel-code to RGB444 lookup with blanking.
// Option macro    : HPU_PALETTE_BACKDROP_EN (shared backdrop, valid gating)
// Rev 1.0
// ============================================================================
module hpu_palette_out
  import hpu_pkg::*;
#(
  parameter logic [15:0] PALETTE_BASE = PALETTE_OFFSET,
  parameter int          NUM_ENTRIES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [4:0]  pixel_in,
  input  logic        active_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [11:0] rgb_out,
  output logic        rgb_valid,
  output logic        palette_valid,
  output logic        load_done
);

  localparam int               c_idx_w = $clog2(NUM_ENTRIES);
  localparam int               c_cnt_w = c_idx_w + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(2 * NUM_ENTRIES - 1);

  load_state_t          r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_byte_cnt, w_cnt_nxt;
  logic [7:0]           r_lo_buf, w_lo_nxt;
  logic                 r_restart, w_restart_nxt;
  logic                 r_palette_valid, w_pv_nxt;
  logic                 w_we;
  rgb444_t              w_wentry;

  logic [4:0]           r_pix1;
  logic                 r_act1;
  logic                 r_act2;
  logic [c_idx_w-1:0]   w_raddr;
  logic [11:0]          w_rdata;

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= LD_IDLE;
      r_byte_cnt      <= '0;
      r_lo_buf        <= '0;
      r_restart       <= 1'b0;
      r_palette_valid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_byte_cnt      <= w_cnt_nxt;
      r_lo_buf        <= w_lo_nxt;
      r_restart       <= w_restart_nxt;
      r_palette_valid <= w_pv_nxt;
    end
  end

  // An abort parks in IDLE for one cycle with r_restart set, giving the
  // single-cycle request gap before fetching resumes from byte 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_byte_cnt;
    w_lo_nxt      = r_lo_buf;
    w_restart_nxt = r_restart;
    w_pv_nxt      = r_palette_valid;
    w_we          = 1'b0;
    mem_req       = 1'b0;
    load_done     = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (frame_start || r_restart) begin
          w_state_nxt   = LD_REQ;
          w_cnt_nxt     = '0;
          w_restart_nxt = 1'b0;
        end
      end
      LD_REQ: begin
        mem_req = 1'b1;
        if (frame_start) begin
          w_state_nxt   = LD_IDLE;
          w_cnt_nxt     = '0;
          w_restart_nxt = 1'b1;
        end else if (mem_ack) begin
          if (!r_byte_cnt[0]) begin
            w_lo_nxt = mem_data;
          end else begin
            w_we = 1'b1;
          end
          w_cnt_nxt = r_byte_cnt + 1'b1;
          if (r_byte_cnt == c_last) begin
            w_state_nxt = LD_STORE;
          end
        end
      end
      LD_STORE: begin
        load_done   = 1'b1;
        w_pv_nxt    = 1'b1;
        w_state_nxt = LD_IDLE;
        if (frame_start) begin
          w_restart_nxt = 1'b1;
        end
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  assign mem_addr      = mem_req ? (PALETTE_BASE + 16'(r_byte_cnt)) : 16'h0000;
  assign palette_valid = r_palette_valid;
  assign w_wentry      = make_entry(r_lo_buf, mem_data[3:0]);

  // ---------------------------------------------------------- lookup pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix1 <= '0;
      r_act1 <= 1'b0;
      r_act2 <= 1'b0;
    end else begin
      r_pix1 <= pixel_in;
      r_act1 <= active_in;
      r_act2 <= r_act1;
    end
  end

`ifdef HPU_PALETTE_BACKDROP_EN
  tile_pixel_t w_tp;
  assign w_tp    = tile_pixel_t'(r_pix1);
  assign w_raddr = (w_tp.idx == 3'd0) ? '0 : r_pix1[c_idx_w-1:0];
  assign rgb_out = (r_act2 && r_palette_valid) ? w_rdata : 12'h000;
`else
  assign w_raddr = r_pix1[c_idx_w-1:0];
  assign rgb_out = r_act2 ? w_rdata : 12'h000;
`endif

  assign rgb_valid = r_act2;

  hpu_palette_ram #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (r_byte_cnt[c_cnt_w-1:1]),
    .wdata (w_wentry),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_hpu_palette_out.sv
`default_nettype none
// Self-checking bench for hpu_palette_out: memory responder with random ack
// latency, table vectors, and a colour-lookup reference model.
module tb_hpu_palette_out;

  localparam logic [15:0] BASE = 16'h2AC0;

  logic        clk = 1'b0;
  logic        reset, frame_start, active_in, mem_ack;
  logic        mem_req, rgb_valid, palette_valid, load_done;
  logic [4:0]  pixel_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  hpu_palette_out #(
    .PALETTE_BASE (BASE),
    .NUM_ENTRIES  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .pixel_in      (pixel_in),
    .active_in     (active_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid),
    .palette_valid (palette_valid),
    .load_done     (load_done)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem_model [64];
  logic [11:0] cache_model [32];
  bit          pv_model;
  int          max_delay = 0;
  int          ld_cnt = 0, req_cycles = 0, acc_cnt = 0, exp_cnt = 0;
  logic        req_n = 1'b0;
  logic [15:0] addr_n = '0;

  logic [11:0] h_exp [2];
  logic        h_vld [2];
  bit          h_chk [2];

  typedef struct {
    logic [4:0]  pix;
    logic        act;
    logic [11:0] rgb;
    logic        vld;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Colour a display driver should see for a pixel, from the palette rules.
  function automatic logic [11:0] exp_rgb(input logic [4:0] p, input logic a);
    int e;
    e = int'(p);
    if (!a) return 12'h000;
`ifdef HPU_PALETTE_BACKDROP_EN
    if (!pv_model) return 12'h000;
    if (e % 8 == 0) e = 0;
`endif
    return cache_model[e];
  endfunction

  // Memory responder: random ack latency, checks request stability.
  initial begin : responder
    bit          waiting;
    int          wait_left;
    logic [15:0] hold_addr;
    logic [15:0] off;
    waiting = 0; wait_left = 0; hold_addr = '0;
    mem_ack = 1'b0; mem_data = 8'h00;
    forever begin
      @(negedge clk);
      req_n   = mem_req;
      addr_n  = mem_addr;
      mem_ack = 1'b0;
      if (load_done) ld_cnt++;
      if (mem_req) begin
        req_cycles++;
        if (!waiting) begin
          waiting   = 1;
          hold_addr = mem_addr;
          wait_left = $urandom_range(0, max_delay);
        end else begin
          chk("addr_stable", mem_addr, hold_addr);
        end
        if (wait_left == 0) begin
          off      = mem_addr - BASE;
          mem_ack  = 1'b1;
          mem_data = (off < 16'd64) ? mem_model[off[5:0]] : 8'h00;
          waiting  = 0;
        end else begin
          wait_left--;
        end
      end else begin
        waiting = 0;
      end
    end
  end

  // Consumed-byte monitor: addresses must run BASE, BASE+1, ... from each frame_start.
  initial begin : monitor
    forever begin
      @(posedge clk);
      if (frame_start) begin
        exp_cnt = 0;
      end else if (req_n && mem_ack && !reset) begin
        chk("addr_order", addr_n, BASE + 16'(exp_cnt));
        exp_cnt++;
        acc_cnt++;
      end
    end
  end

  task automatic pix_step(input logic [4:0] p, input logic a, input bit c);
    @(negedge clk);
    if (h_chk[1]) begin
      chk("pipe_rgb", rgb_out, h_exp[1]);
      chk("pipe_valid", rgb_valid, h_vld[1]);
    end
    h_chk[1] = h_chk[0]; h_exp[1] = h_exp[0]; h_vld[1] = h_vld[0];
    h_chk[0] = c;        h_exp[0] = exp_rgb(p, a); h_vld[0] = a;
    pixel_in  = p;
    active_in = a;
  endtask

  task automatic pix_flush();
    pix_step(5'd0, 1'b0, 1'b0);
    pix_step(5'd0, 1'b0, 1'b0);
    h_chk[0] = 0; h_chk[1] = 0;
  endtask

  task automatic sweep_and_random(input int n_rand);
    for (int c = 0; c < 32; c++) pix_step(5'(c), 1'b1, 1'b1);
    for (int i = 0; i < n_rand; i++) pix_step(5'($urandom), 1'($urandom), 1'b1);
    pix_flush();
  endtask

  task automatic finish_load(input int ld0, input bit zero_wait);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk); #1;
      if (ld_cnt != ld0) seen = 1;
    end
    chk("load_timeout", 16'(seen), 16'd1);
    repeat (3) @(negedge clk);
    chk("load_done_count", 16'(ld_cnt - ld0), 16'd1);
    chk("bytes_fetched", 16'(exp_cnt), 16'd64);
    chk("palette_valid", 16'(palette_valid), 16'd1);
    if (zero_wait) chk("req_cycles", 16'(req_cycles), 16'd64);
    for (int n = 0; n < 32; n++) cache_model[n] = {mem_model[2*n+1][3:0], mem_model[2*n]};
    pv_model = 1;
  endtask

  task automatic start_load(input int dly);
    max_delay = dly;
    @(negedge clk); frame_start = 1'b1;
    req_cycles = 0;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (acc_cnt >= target) seen = 1;
    end
    chk(name, 16'(seen), 16'd1);
  endtask

  initial begin : main
    int ld0, acc0;
    logic [11:0] e;
    reset = 1'b1; frame_start = 1'b0; pixel_in = '0; active_in = 1'b0;
    pv_model = 0;
    h_chk[0] = 0; h_chk[1] = 0;
    for (int n = 0; n < 32; n++) cache_model[n] = 12'h000;
    for (int n = 0; n < 64; n++) mem_model[n] = 8'h00;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mem_req", 16'(mem_req), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_rgb_out", 16'(rgb_out), 16'h000);
    chk("rst_rgb_valid", 16'(rgb_valid), 16'd0);
    chk("rst_palette_valid", 16'(palette_valid), 16'd0);
    chk("rst_load_done", 16'(load_done), 16'd0);
    for (int i = 0; i < 8; i++) pix_step(5'($urandom), 1'b1, 1'b1);
    pix_flush();

    // Uniform palette, zero-wait memory; upper nibble of red byte must be dropped
    for (int n = 0; n < 32; n++) begin
      mem_model[2*n] = 8'h5A; mem_model[2*n+1] = 8'hF3;
    end
    ld0 = ld_cnt;
    start_load(0);
    finish_load(ld0, 1'b1);
    sweep_and_random(0);

    // Distinct palette and fixed vectors
    for (int n = 0; n < 32; n++) begin
      e = (n == 11) ? 12'hABC : 12'(12'h800 + n * 3);
      mem_model[2*n]   = e[7:0];
      mem_model[2*n+1] = {4'($urandom), e[11:8]};
    end
    ld0 = ld_cnt;
    start_load(0);
    finish_load(ld0, 1'b1);
    tbl[0] = '{5'b01_011, 1'b1, 12'hABC, 1'b1};
    tbl[1] = '{5'b01_011, 1'b0, 12'h000, 1'b0};
    tbl[2] = '{5'b00_000, 1'b1, 12'h800, 1'b1};
    tbl[3] = '{5'b11_111, 1'b1, 12'h85D, 1'b1};
    tbl[5] = '{5'b00_001, 1'b1, 12'h803, 1'b1};
    tbl[7] = '{5'b10_101, 1'b0, 12'h000, 1'b0};
`ifdef HPU_PALETTE_BACKDROP_EN
    tbl[4] = '{5'b10_000, 1'b1, 12'h800, 1'b1};
    tbl[6] = '{5'b01_000, 1'b1, 12'h800, 1'b1};
`else
    tbl[4] = '{5'b10_000, 1'b1, 12'h830, 1'b1};
    tbl[6] = '{5'b01_000, 1'b1, 12'h818, 1'b1};
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pixel_in  = tbl[i].pix;
      active_in = tbl[i].act;
      repeat (2) @(negedge clk);
      chk($sformatf("tbl%0d_rgb", i), 16'(rgb_out), 16'(tbl[i].rgb));
      chk($sformatf("tbl%0d_valid", i), 16'(rgb_valid), 16'(tbl[i].vld));
    end
    pix_flush();

    // Random palette with random ack latency 0..5
    for (int n = 0; n < 64; n++) mem_model[n] = 8'($urandom);
    ld0 = ld_cnt;
    start_load(5);
    finish_load(ld0, 1'b0);
    sweep_and_random(60);

    // Abort after 20 bytes, restart from the base address
    for (int n = 0; n < 64; n++) mem_model[n] = 8'($urandom);
    ld0 = ld_cnt; acc0 = acc_cnt;
    start_load(0);
    wait_bytes(acc0 + 20, "abort_reach20");
    frame_start = 1'b1;
    chk("abort_req_before", 16'(mem_req), 16'd1);
    @(negedge clk); frame_start = 1'b0;
    chk("abort_req_drop", 16'(mem_req), 16'd0);
    @(negedge clk);
    chk("abort_req_resume", 16'(mem_req), 16'd1);
    chk("abort_addr_restart", mem_addr, BASE);
    finish_load(ld0, 1'b0);
    sweep_and_random(20);

    // Reset in the middle of a refill
    for (int n = 0; n < 64; n++) mem_model[n] = 8'($urandom);
    acc0 = acc_cnt;
    start_load(2);
    wait_bytes(acc0 + 10, "midload_reach10");
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", 16'(mem_req), 16'd0);
    chk("midrst_palette_valid", 16'(palette_valid), 16'd0);
    chk("midrst_load_done", 16'(load_done), 16'd0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 32; n++) cache_model[n] = 12'h000;
    pv_model = 0;
    h_chk[0] = 0; h_chk[1] = 0;
    sweep_and_random(0);
    chk("post_rst_idle_req", 16'(mem_req), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
